// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) helpers for the iterative encryption core.
package aes_pkg;

    localparam int unsigned NR = 10;
    localparam int unsigned NB = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } fsm_e;

    // Round constant for rounds 1..10; other indices never reach the key schedule.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcolumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Byte i lives at [127-8i -: 8]; row r of column c is byte r + 4c.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < int'(NB); c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (row + 4 * c) -: 8] = s[127 - 8 * (row + 4 * ((c + row) % 4)) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes128_enc_iter_if.sv
// Handshake bundle for aes128_enc_iter; the abort input exists only when AES_ENC_ABORT_EN is defined.
interface aes128_enc_iter_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
`ifdef AES_ENC_ABORT_EN
    logic         abort;
`endif

    modport master (
        output in_valid,
        output plaintext,
        output key,
        output out_ready,
`ifdef AES_ENC_ABORT_EN
        output abort,
`endif
        input  in_ready,
        input  out_valid,
        input  ciphertext
    );

    modport slave (
        input  in_valid,
        input  plaintext,
        input  key,
        input  out_ready,
`ifdef AES_ENC_ABORT_EN
        input  abort,
`endif
        output in_ready,
        output out_valid,
        output ciphertext
    );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box as a combinational 256-entry lookup.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Optional AES_ENC_ABORT_EN adds an abort input that cancels a transaction in BUSY.
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int unsigned NR = aes_pkg::NR
) (
    input logic              clk,
    input logic              rst,
    aes128_enc_iter_if.slave bus
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    fsm_e         fsm_q;
    logic [127:0] state_q;
    logic [127:0] rk_q;
    logic [127:0] ct_q;
    logic [3:0]   rnd_q;
    logic         out_valid_q;

    logic [127:0] sub_bytes;
    logic [127:0] shift_rows;
    logic [127:0] mix_cols;
    logic [127:0] rk_next;
    logic [127:0] round_out;
    logic [31:0]  sub_word;
    logic [31:0]  key_temp;

    for (genvar i = 0; i < 16; i++) begin : g_state_sbox
        aes_sbox u_sbox (
            .din  (state_q[127 - 8 * i -: 8]),
            .dout (sub_bytes[127 - 8 * i -: 8])
        );
    end

    for (genvar i = 0; i < 4; i++) begin : g_key_sbox
        aes_sbox u_sbox (
            .din  (rk_q[31 - 8 * i -: 8]),
            .dout (sub_word[31 - 8 * i -: 8])
        );
    end

    always_comb begin
        shift_rows = shiftrows(sub_bytes);
        mix_cols   = '0;
        for (int c = 0; c < 4; c++) begin
            mix_cols[127 - 32 * c -: 32] = mixcolumn(shift_rows[127 - 32 * c -: 32]);
        end
        // SubWord is applied before RotWord; byte-wise S-box commutes with the rotation.
        key_temp         = {sub_word[23:0], sub_word[31:24]} ^ {rcon(rnd_q), 24'h0};
        rk_next[127:96]  = rk_q[127:96] ^ key_temp;
        rk_next[95:64]   = rk_q[95:64] ^ rk_next[127:96];
        rk_next[63:32]   = rk_q[63:32] ^ rk_next[95:64];
        rk_next[31:0]    = rk_q[31:0] ^ rk_next[63:32];
        round_out        = ((rnd_q == LAST_RND) ? shift_rows : mix_cols) ^ rk_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            rk_q        <= '0;
            ct_q        <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_q <= bus.plaintext ^ bus.key;
                        rk_q    <= bus.key;
                        rnd_q   <= 4'd1;
                        fsm_q   <= BUSY;
                    end
                end
                BUSY: begin
`ifdef AES_ENC_ABORT_EN
                    if (bus.abort) begin
                        state_q <= '0;
                        rk_q    <= '0;
                        rnd_q   <= '0;
                        fsm_q   <= IDLE;
                    end else
`endif
                    begin
                        state_q <= round_out;
                        rk_q    <= rk_next;
                        if (rnd_q == LAST_RND) begin
                            ct_q        <= round_out;
                            out_valid_q <= 1'b1;
                            rnd_q       <= '0;
                            fsm_q       <= DONE;
                        end else begin
                            rnd_q <= rnd_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        fsm_q       <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (fsm_q == IDLE) && !rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.ciphertext = ct_q;

    rnd_in_range: assert property (@(posedge clk) disable iff (rst) rnd_q <= LAST_RND);

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Directed scoreboard bench for aes128_enc_iter using FIPS-197 vectors; abort steps need AES_ENC_ABORT_EN.
module tb_aes128_enc_iter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes128_enc_iter_if bus ();

    aes128_enc_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [127:0] sb_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [127:0] pt, input logic [127:0] k,
                        input logic [127:0] exp);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, {127'b0, bus.in_ready}, 128'd1);
        bus.plaintext = pt;
        bus.key       = k;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        sb_q.push_back(exp);
    endtask

    // Counts edges after accept until out_valid; churn drives junk requests meanwhile.
    task automatic wait_out(input string tag, input bit churn);
        int cycles;
        cycles = 0;
        while (bus.out_valid !== 1'b1 && cycles < 50) begin
            if (churn) begin
                bus.in_valid  = 1'b1;
                bus.plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
                bus.key       = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            tick();
            cycles++;
        end
        bus.in_valid = 1'b0;
        check({tag, "_latency"}, 128'(cycles), 128'd10);
    endtask

    task automatic collect(input string tag);
        logic [127:0] exp;
        exp = '0;
        if (sb_q.size() != 0) exp = sb_q.pop_front();
        check({tag, "_out_valid"}, {127'b0, bus.out_valid}, 128'd1);
        check({tag, "_ct"}, bus.ciphertext, exp);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, {127'b0, bus.out_valid}, 128'd0);
        check({tag, "_ready_back"}, {127'b0, bus.in_ready}, 128'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen++;
        end
        check({tag, "_no_out_valid"}, 128'(seen), 128'd0);
    endtask

    initial begin
        #100us;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
        bus.out_ready = 1'b0;
`ifdef AES_ENC_ABORT_EN
        bus.abort     = 1'b0;
`endif
        tick();
        tick();
        check("rst_in_ready", {127'b0, bus.in_ready}, 128'd0);
        check("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("rst_ct", bus.ciphertext, 128'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", {127'b0, bus.in_ready}, 128'd1);

        send("appb", PT_B, KEY_B, CT_B);
        wait_out("appb", 1'b0);
        collect("appb");

        // out_ready held high before any result exists must not matter
        bus.out_ready = 1'b1;
        send("c1", PT_C1, KEY_C1, CT_C1);
        wait_out("c1", 1'b0);
        collect("c1");

        send("bp", PT_B, KEY_B, CT_B);
        wait_out("bp", 1'b0);
        for (int i = 0; i < 7; i++) begin
            bus.in_valid  = 1'b1;
            bus.plaintext = PT_C1;
            bus.key       = KEY_C1;
            tick();
            check("bp_hold_valid", {127'b0, bus.out_valid}, 128'd1);
            check("bp_hold_ct", bus.ciphertext, CT_B);
            check("bp_in_ready", {127'b0, bus.in_ready}, 128'd0);
        end
        bus.in_valid = 1'b0;
        collect("bp");
        quiet("bp_after", 12);

        send("churn", PT_B, KEY_B, CT_B);
        wait_out("churn", 1'b1);
        collect("churn");
        quiet("churn_after", 12);

        send("rstmid", PT_B, KEY_B, CT_B);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", {127'b0, bus.out_valid}, 128'd0);
        check("rstmid_ct", bus.ciphertext, 128'd0);
        check("rstmid_in_ready", {127'b0, bus.in_ready}, 128'd0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_rel_ready", {127'b0, bus.in_ready}, 128'd1);
        quiet("rstmid", 15);
        send("post_rst", PT_C1, KEY_C1, CT_C1);
        wait_out("post_rst", 1'b0);
        collect("post_rst");

`ifdef AES_ENC_ABORT_EN
        send("abort", PT_C1, KEY_C1, CT_C1);
        repeat (2) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_in_ready", {127'b0, bus.in_ready}, 128'd1);
        check("abort_out_valid", {127'b0, bus.out_valid}, 128'd0);
        sb_q.delete();
        quiet("abort", 15);
        send("post_abort", PT_B, KEY_B, CT_B);
        wait_out("post_abort", 1'b0);
        collect("post_abort");
`endif

        check("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
